// File: rtl/alu_issue_queue.sv
// Command FIFO and issue sequencer sitting in front of the 4-bit ALU.
// Define ALU_ISSUE_STATS_EN to add saturating result/error handoff counters.

package alu_issue_queue_pkg;
    localparam int unsigned OPND_W = 4;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned RES_W  = 8;
    localparam int unsigned STAT_W = 16;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [OP_W-1:0]   s;
    } alu_cmd_t;
endpackage

module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_s,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_s,
    output logic              alu_rst,
    input  logic [RES_W-1:0]  alu_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              res_err
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_cmds,
    output logic [STAT_W-1:0] stat_errs
`endif
);

    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t            state;
    alu_cmd_t          mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    alu_cmd_t          in_cmd_c;
    alu_cmd_t          head_c;
    logic              push_c;
    logic              pop_c;

    assign alu_rst  = ~reset;
    assign in_ready = reset & (count != CNT_W'(DEPTH));
    assign in_cmd_c = '{a: in_a, b: in_b, s: in_s};
    assign head_c   = mem[rd_ptr];
    assign push_c   = in_valid & in_ready;

    // Pop from IDLE, or straight out of RESULT on the handshake edge (back-to-back issue).
    assign pop_c = (count != '0) &
                   ((state == IDLE) | ((state == RESULT) & res_ready));

    // Payload storage needs no reset; a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= in_cmd_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Issue sequencer: illegal opcodes bypass the ALU and report an error result directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
        end else if (pop_c) begin
            if (head_c.s[OP_W-1]) begin
                res_data  <= '0;
                res_err   <= 1'b1;
                res_valid <= 1'b1;
                state     <= RESULT;
            end else begin
                alu_a     <= head_c.a;
                alu_b     <= head_c.b;
                alu_s     <= head_c.s;
                res_valid <= 1'b0;
                state     <= DRIVE;
            end
        end else begin
            unique case (state)
                DRIVE: begin
                    res_data  <= alu_y;
                    res_err   <= 1'b0;
                    res_valid <= 1'b1;
                    state     <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic res_fire_c;

    assign res_fire_c = res_valid & res_ready;

    // Saturating handoff counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_cmds <= '0;
            stat_errs <= '0;
        end else if (res_fire_c) begin
            if (stat_cmds != '1) begin
                stat_cmds <= stat_cmds + STAT_W'(1);
            end
            if (res_err && (stat_errs != '1)) begin
                stat_errs <= stat_errs + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed scoreboard bench for alu_issue_queue with a behavioural 4-bit ALU attached.

module tb_alu_issue_queue;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_s;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_s;
    logic       alu_rst;
    logic [7:0] alu_y;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_err;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_cmds;
    logic [15:0] stat_errs;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [8:0] exp_q [$];
    logic [7:0] hs_data [$];
    int         hs_cyc [$];

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_s      (in_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_rst   (alu_rst),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stat_cmds (stat_cmds),
        .stat_errs (stat_errs)
`endif
    );

    // Behavioural ALU; unimplemented opcodes give a junk value that must never be forwarded.
    always_comb begin
        case (alu_s)
            3'b000:  alu_y = 8'(alu_a) + 8'(alu_b);
            3'b001:  alu_y = 8'(alu_a) - 8'(alu_b);
            3'b010:  alu_y = {4'h0, alu_a & alu_b};
            3'b011:  alu_y = {4'h0, alu_a | alu_b};
            default: alu_y = 8'hAA;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] s);
        logic [7:0] ea;
        logic [7:0] eb;
        ea = {4'h0, a};
        eb = {4'h0, b};
        if (s[2]) return 9'h100;
        case (s[1:0])
            2'b00:   return {1'b0, 8'(ea + eb)};
            2'b01:   return {1'b0, 8'(ea - eb)};
            2'b10:   return {1'b0, ea & eb};
            default: return {1'b0, ea | eb};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Account for the handshakes about to happen at the next rising edge, then advance one cycle.
    task automatic tick();
        logic [8:0] e;
        if (reset && res_valid && res_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_result", {23'h0, res_err, res_data}, {23'h0, e});
            end
            hs_data.push_back(res_data);
            hs_cyc.push_back(cyc);
        end
        if (reset && in_valid && in_ready) begin
            exp_q.push_back(model(in_a, in_b, in_s));
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_s     = s;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        chk("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!res_valid && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_one(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] s, input int lat, input logic [7:0] data,
                           input logic err);
        int n;
        res_ready = 1'b1;
        send(a, b, s);
        wait_valid(8, n);
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_data"}, {24'h0, res_data}, {24'h0, data});
        chk({tag, "_err"}, 32'(res_err), 32'(err));
        tick();
        chk({tag, "_idle"}, 32'(res_valid), 32'd0);
    endtask

    // Fill with res_ready low; DEPTH in the FIFO plus one held in the result stage.
    task automatic capacity(input string tag);
        int acc_n;
        acc_n     = 0;
        res_ready = 1'b0;
        in_valid  = 1'b1;
        hs_data.delete();
        for (int i = 0; i < 10; i++) begin
            in_a = 4'(acc_n + 1);
            in_b = 4'(3 * acc_n);
            in_s = (acc_n == 3) ? 3'b110 : 3'(acc_n % 4);
            if (in_ready) acc_n++;
            tick();
        end
        in_valid = 1'b0;
        chk({tag, "_accepts"}, 32'(acc_n), 32'(DEPTH + 1));
        chk({tag, "_full"}, 32'(in_ready), 32'd0);
        res_ready = 1'b1;
        tick();
        chk({tag, "_ready_on_pop"}, 32'(in_ready), 32'd1);
        drain(40);
        chk({tag, "_drained"}, 32'(hs_data.size()), 32'(DEPTH + 1));
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_s      = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        chk("rst_res_data", {24'h0, res_data}, 32'd0);
        chk("rst_alu_pins", {21'h0, alu_a, alu_b, alu_s}, 32'd0);
        chk("rst_alu_rst", 32'(alu_rst), 32'd1);
        reset = 1'b1;
        tick();
        chk("run_in_ready", 32'(in_ready), 32'd1);
        chk("run_alu_rst", 32'(alu_rst), 32'd0);

        // Single legal and illegal commands with latency
        run_one("add", 4'd7, 4'd9, 3'b000, 2, 8'h10, 1'b0);
        run_one("sub", 4'd3, 4'd5, 3'b001, 2, 8'hFE, 1'b0);

        send(4'd1, 4'd1, 3'b101);
        wait_valid(8, n);
        chk("ill_latency", 32'(n), 32'd1);
        chk("ill_data", {24'h0, res_data}, 32'd0);
        chk("ill_err", 32'(res_err), 32'd1);
        chk("ill_alu_s_kept", 32'(alu_s), 32'(3'b001));
        chk("ill_alu_a_kept", 32'(alu_a), 32'd3);
        tick();
        chk("ill_idle", 32'(res_valid), 32'd0);

        // Back-to-back legal commands
        hs_data.delete();
        hs_cyc.delete();
        send(4'hC, 4'hA, 3'b010);
        send(4'hC, 4'hA, 3'b011);
        drain(20);
        chk("b2b_count", 32'(hs_data.size()), 32'd2);
        chk("b2b_first", {24'h0, hs_data[0]}, 32'h08);
        chk("b2b_second", {24'h0, hs_data[1]}, 32'h0E);
        chk("b2b_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);

        capacity("cap");

        // Reset in the middle of DRIVE with commands queued
        res_ready = 1'b0;
        send(4'h2, 4'h3, 3'b000);
        send(4'h4, 4'h4, 3'b010);
        send(4'h5, 4'h1, 3'b001);
        res_ready = 1'b1;
        tick();
        chk("mid_in_drive", 32'(res_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("mrst_res_valid", 32'(res_valid), 32'd0);
        chk("mrst_res_data", {24'h0, res_data}, 32'd0);
        chk("mrst_alu_pins", {21'h0, alu_a, alu_b, alu_s}, 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("no_replay", 32'(res_valid), 32'd0);
            tick();
        end
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // Count must have cleared: full capacity is available again
        capacity("cap2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
